// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 pins, deframes scan-code bytes
// and queues them in a show-ahead FIFO. Optional host inhibit on FIFO full: define PS2_INHIBIT_EN.
module ps2_keyboard #(
  parameter int FILTER     = 4,
  parameter int TIMEOUT    = 5000,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       CLOCK,
  input  logic       RESET,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READ,
  output logic       ERR,
  output logic       OVERFLOW
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int FW    = $clog2(FILTER + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------------------
  // Input path: bit 0 is the PS/2 clock, bit 1 is the PS/2 data line
  // ---------------------------------------------------------------------------
  logic [1:0] pin_in;
  logic [1:0] filt;

  assign pin_in = {PS2_DAT, PS2_CLK};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_filt
      logic          meta_reg;
      logic          sync_reg;
      logic          filt_reg;
      logic [FW-1:0] cnt_reg;

      always_ff @(posedge CLOCK) begin
        if (RESET) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
          filt_reg <= 1'b1;
          cnt_reg  <= '0;
        end else begin
          meta_reg <= pin_in[gi];
          sync_reg <= meta_reg;
          if (sync_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == FW'(FILTER - 1)) begin
            filt_reg <= sync_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + FW'(1);
          end
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  logic filt_clk_d_reg;
  logic fall;
  logic dat;

  always_ff @(posedge CLOCK) begin
    if (RESET) filt_clk_d_reg <= 1'b1;
    else       filt_clk_d_reg <= filt[0];
  end

  assign fall = filt_clk_d_reg & ~filt[0];
  assign dat  = filt[1];

  // ---------------------------------------------------------------------------
  // FIFO status (needed by the frame FSM for inhibit)
  // ---------------------------------------------------------------------------
  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2:0] rd_ptr_reg, rd_ptr_next;
  logic                empty, full, pop, wr_en, bypass;
  logic [7:0]          data_reg;
  logic                valid_reg;
  logic                overflow_reg;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                 (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          push_reg, push_next;
  logic          err_reg, err_next;
  logic          inhibit;

`ifdef PS2_INHIBIT_EN
  logic inhibit_reg;

  assign inhibit = full && (state_reg == S_IDLE);

  always_ff @(posedge CLOCK) begin
    if (RESET) inhibit_reg <= 1'b0;
    else       inhibit_reg <= inhibit;
  end

  assign PS2_CLK = inhibit_reg ? 1'b0 : 1'bz;
`else
  assign inhibit = 1'b0;
  assign PS2_CLK = 1'bz;
`endif

  assign PS2_DAT = 1'bz;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg   <= S_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      timer_reg   <= '0;
      push_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      timer_reg   <= timer_next;
      push_reg    <= push_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    timer_next   = '0;
    push_next    = 1'b0;
    err_next     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (fall && !dat && !inhibit) begin
          state_next   = S_DATA;
          bit_cnt_next = '0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_next   = {dat, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          parity_next = dat;
          state_next  = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          // shift_reg stays untouched in IDLE, so it still holds the byte when push_reg fires
          if (dat && (^{shift_reg, parity_reg})) push_next = 1'b1;
          else                                   err_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (state_reg != S_IDLE && !fall) begin
      if (timer_reg == TW'(TIMEOUT - 1)) begin
        state_next = S_IDLE;
        err_next   = 1'b1;
      end else begin
        timer_next = timer_reg + TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO with a registered head byte
  // ---------------------------------------------------------------------------
  assign pop   = READ && !empty;
  assign wr_en = push_reg && (!full || pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (wr_en) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop)   rd_ptr_next = rd_ptr_reg + PTR_ONE;
  end

  // The byte being written is the new head only when the FIFO would otherwise be empty
  assign bypass = wr_en && (wr_ptr_reg == rd_ptr_next);

  always_ff @(posedge CLOCK) begin
    if (wr_en) mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= shift_reg;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      data_reg   <= 8'h00;
      valid_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      valid_reg  <= (wr_ptr_next != rd_ptr_next);
      if (wr_ptr_next == rd_ptr_next) data_reg <= 8'h00;
      else if (bypass)                data_reg <= shift_reg;
      else                            data_reg <= mem[rd_ptr_next[DEPTH_LOG2-1:0]];
    end
  end

`ifdef PS2_INHIBIT_EN
  always_ff @(posedge CLOCK) begin
    if (RESET) overflow_reg <= 1'b0;
    else       overflow_reg <= 1'b0;
  end
`else
  always_ff @(posedge CLOCK) begin
    if (RESET)                          overflow_reg <= 1'b0;
    else if (push_reg && full && !pop)  overflow_reg <= 1'b1;
  end
`endif

  assign DATA     = data_reg;
  assign VALID    = valid_reg;
  assign ERR      = err_reg;
  assign OVERFLOW = overflow_reg;

endmodule
